pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, 3-stage pipelined barrel shifter for the datapath. Left shifts are done as reverse, then right shift, then reverse back, so only one right-shift network is built.
- Supports logical left, logical right and arithmetic right shifts, with an optional rotate mode.
- Uses a valid/ready handshake on both sides and sits between the ALU operand registers and the writeback mux.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width; localparam derived from WIDTH, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  shifter can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_dir  input  1  0 = right, 1 = left.
- in_arith  input  1  1 = arithmetic (sign fill); honoured for right shifts only.
- in_rot  input  1  rotate request; only active with ROTATE_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all stage valid bits clear, all data and control registers clear. After reset, out_valid=0, out_data=0, in_ready=1.
- Pipeline advance: adv = !s3_valid || out_ready. All three stages move together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. A beat is accepted when in_valid && in_ready.
- S1 capture (on adv):
  - s1_data = bit-reverse of in_data if in_dir=1, else in_data.
  - Also captures shamt, dir, fill and rot.
  - s1_valid = in_valid.
- Fill bit:
  - in_data[WIDTH-1] when in_dir=0 and in_arith=1.
  - 0 in every other case, including arith with left: this is a logical left shift.
- S2 (on adv): s2_data = s1_data shifted right by s1_shamt.
  - Built as SHW cascaded 2:1 mux levels; level k shifts by 2^k.
  - Vacated MSBs take the fill bit.
- S3 (on adv): s3_data = bit-reverse of s2_data if dir=1, else s2_data.
  - out_data = s3_data; out_valid = s3_valid.
- Latency and throughput: an accepted beat appears on out_data exactly 3 cycles later when there is no stall. Throughput is 1 beat per cycle. Beats stay in order.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_valid hold stable.
  - in_ready=0 and no stage changes.
- Bubbles: invalid stages still advance when adv=1. A bubble in S3 never blocks the pipe, because adv=1 whenever !s3_valid.
- Boundary values:
  - shamt=0 passes data through unchanged in every mode.
  - shamt=WIDTH-1 with arithmetic right gives all sign bits, except bit 0 = original MSB.
- Reset mid-operation: rst wins over adv. All in-flight beats are discarded and none is emitted after rst deasserts.

Optional Feature:
- Macro: BARREL_ROTATE_EN.
- Defined:
  - in_rot=1 selects rotate in the given direction; in_rot overrides in_arith.
  - S2 performs a circular right rotate: bits leaving LSB re-enter at MSB.
  - Left rotate is produced by the same reverse-rotate-reverse path.
- Undefined:
  - in_rot is ignored (not registered) and S2 holds no rotate muxes.
  - A request with in_rot=1 behaves exactly as the same request with in_rot=0.

Test Plan:
- Reset then idle -> out_valid=0, out_data=0, in_ready=1 for 5 cycles.
- WIDTH=8, single beat data=8'b1011_0001, shamt=3, dir=1 -> 3 cycles later out_data=8'b1000_1000 with out_valid pulsed for 1 cycle.
- data=8'h96, shamt=2, dir=0: arith=1 -> 8'hE5; arith=0 -> 8'h25; dir=1, arith=1 -> 8'h58 (arith ignored for left).
- Stream of 6 back-to-back beats (shamt 0..5, data 8'hFF, dir=0) with out_ready=0 for cycles 4-6:
  - out_data holds during the stall and in_ready=0.
  - Results emerge in order: FF, 7F, 3F, 1F, 0F, 07; none lost or duplicated.
- Assert rst with 3 beats in flight -> next cycle out_valid=0; no stale result appears after release.
- BARREL_ROTATE_EN defined: data=8'h81, shamt=1, rot=1, dir=0 -> 8'hC0; dir=1 -> 8'h03. Macro undefined: dir=0 -> 8'h40.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Three-stage pipelined barrel shifter: reverse / right-shift network / reverse, valid-ready on both sides.
// Optional rotate mode is compiled in with `define BARREL_ROTATE_EN.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic             in_arith,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
    return {<<{d}};
  endfunction

  // Sign fill only for arithmetic right shifts; rotate ignores the fill entirely.
  function automatic logic fill_bit(input logic msb, input logic dir, input logic arith,
                                    input logic rot);
    return msb & ~dir & arith & ~rot;
  endfunction

  logic             vld_p0_q, vld_p1_q, vld_p2_q;
  logic [WIDTH-1:0] data_p0_q, data_p1_q, data_p2_q;
  logic [WIDTH-1:0] data_p0_d, data_p1_d, data_p2_d;
  logic [SHW-1:0]   shamt_p0_q;
  logic             dir_p0_q, dir_p1_q;
  logic             fill_p0_q, fill_p0_d;
  logic             rot_in;
  logic             adv;

`ifdef BARREL_ROTATE_EN
  logic rot_p0_q;
  assign rot_in = in_rot;
`else
  logic unused_rot;
  assign unused_rot = in_rot;
  assign rot_in     = 1'b0;
`endif

  assign adv       = !vld_p2_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;

  // S1 next-state: pre-reverse for left shifts and resolve the fill bit.
  always_comb begin
    data_p0_d = in_dir ? bit_rev(in_data) : in_data;
    fill_p0_d = fill_bit(in_data[WIDTH-1], in_dir, in_arith, rot_in);
  end

  // S2 network: SHW cascaded 2:1 levels, level k shifts right by 2^k.
  logic [SHW:0][WIDTH-1:0] lvl;
  assign lvl[0] = data_p0_q;

  for (genvar k = 0; k < SHW; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int SRC  = (i + (1 << k)) % WIDTH;
      localparam bit WRAP = (i + (1 << k)) >= WIDTH;
      logic shifted;
      if (WRAP) begin : g_wrap
`ifdef BARREL_ROTATE_EN
        assign shifted = rot_p0_q ? lvl[k][SRC] : fill_p0_q;
`else
        assign shifted = fill_p0_q;
`endif
      end else begin : g_in
        assign shifted = lvl[k][SRC];
      end
      assign lvl[k+1][i] = shamt_p0_q[k] ? shifted : lvl[k][i];
    end
  end

  always_comb begin
    data_p1_d = lvl[SHW];
    data_p2_d = dir_p1_q ? bit_rev(data_p1_q) : data_p1_q;
  end

  // Whole pipe advances in lockstep; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      data_p0_q  <= '0;
      data_p1_q  <= '0;
      data_p2_q  <= '0;
      shamt_p0_q <= '0;
      dir_p0_q   <= 1'b0;
      dir_p1_q   <= 1'b0;
      fill_p0_q  <= 1'b0;
`ifdef BARREL_ROTATE_EN
      rot_p0_q   <= 1'b0;
`endif
    end else if (adv) begin
      // stage 1
      vld_p0_q   <= in_valid;
      data_p0_q  <= data_p0_d;
      shamt_p0_q <= in_shamt;
      dir_p0_q   <= in_dir;
      fill_p0_q  <= fill_p0_d;
`ifdef BARREL_ROTATE_EN
      rot_p0_q   <= in_rot;
`endif
      // stage 2
      vld_p1_q   <= vld_p0_q;
      data_p1_q  <= data_p1_d;
      dir_p1_q   <= dir_p0_q;
      // stage 3
      vld_p2_q   <= vld_p1_q;
      data_p2_q  <= data_p2_d;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed cases plus random traffic
// against an arithmetic shift model and a 3-deep lockstep delay line.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int SW = $clog2(W);
`ifdef BARREL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, in_dir, in_arith, in_rot, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shamt(in_shamt),
    .in_dir(in_dir), .in_arith(in_arith), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic         mv [3];
  logic [W-1:0] md [3];
  logic         obs_valid, obs_ready;
  logic [W-1:0] obs_data;
  logic         log_en = 1'b0;
  logic [W-1:0] got_q [$];
  logic [W-1:0] exp_s [6] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic dir,
                                             input logic arith, input logic rot);
    logic signed [W-1:0] sd;
    sd = d;
    if (rot && ROT_EN) return dir ? ((d << s) | (d >> (W - s))) : ((d >> s) | (d << (W - s)));
    if (dir) return d << s;
    if (arith) return sd >>> s;
    return d >> s;
  endfunction

  task automatic tick(input logic v, input logic [W-1:0] d, input int s, input logic dir,
                      input logic arith, input logic rot, input logic oready, input logic r);
    logic adv_m;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; in_shamt = s[SW-1:0];
    in_dir = dir; in_arith = arith; in_rot = rot; out_ready = oready;
    #1;
    obs_valid = out_valid; obs_data = out_data; obs_ready = in_ready;
    chk("out_valid", W'(out_valid), W'(mv[2]));
    if (mv[2]) chk("out_data", out_data, md[2]);
    adv_m = !mv[2] || oready;
    chk("in_ready", W'(in_ready), W'(adv_m));
    if (log_en && out_valid && oready) got_q.push_back(out_data);
    if (r) begin
      for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = '0; end
    end else if (adv_m) begin
      mv[2] = mv[1]; md[2] = md[1];
      mv[1] = mv[0]; md[1] = md[0];
      mv[0] = v;     md[0] = ref_shift(d, s, dir, arith, rot);
    end
  endtask

  task automatic idle(input logic oready);
    tick(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, oready, 1'b0);
  endtask

  task automatic single(input string tag, input logic [W-1:0] d, input int s, input logic dir,
                        input logic arith, input logic rot, input logic [W-1:0] exp);
    tick(1'b1, d, s, dir, arith, rot, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk({tag, "_data"}, obs_data, exp);
    chk({tag, "_vld"}, W'(obs_valid), W'(1));
    idle(1'b1);
    chk({tag, "_pulse"}, W'(obs_valid), W'(0));
  endtask

  initial begin
    int idx, cyc;
    logic or_v, prev_v, prev_or;
    logic [W-1:0] prev_d;

    for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = '0; end
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_dir = 1'b0; in_arith = 1'b0; in_rot = 1'b0; out_ready = 1'b1;

    // reset then idle
    tick(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("rst_vld", W'(obs_valid), W'(0));
      chk("rst_data", obs_data, '0);
      chk("rst_rdy", W'(obs_ready), W'(1));
    end

    // directed single beats
    single("left3", 8'hB1, 3, 1'b1, 1'b0, 1'b0, 8'h88);
    single("asr2", 8'h96, 2, 1'b0, 1'b1, 1'b0, 8'hE5);
    single("lsr2", 8'h96, 2, 1'b0, 1'b0, 1'b0, 8'h25);
    single("lsl2_arith", 8'h96, 2, 1'b1, 1'b1, 1'b0, 8'h58);
    single("asr7", 8'h96, 7, 1'b0, 1'b1, 1'b0, 8'hFF);
    single("sh0", 8'hA5, 0, 1'b1, 1'b1, 1'b0, 8'hA5);
`ifdef BARREL_ROTATE_EN
    single("rotr1", 8'h81, 1, 1'b0, 1'b0, 1'b1, 8'hC0);
    single("rotl1", 8'h81, 1, 1'b1, 1'b0, 1'b1, 8'h03);
`else
    single("norotr1", 8'h81, 1, 1'b0, 1'b0, 1'b1, 8'h40);
    single("norotl1", 8'h81, 1, 1'b1, 1'b0, 1'b1, 8'h02);
`endif

    // back-to-back stream with a 3-cycle output stall
    log_en = 1'b1;
    got_q.delete();
    idx = 0; cyc = 0; prev_v = 1'b0; prev_or = 1'b1; prev_d = '0;
    while (idx < 6 && cyc < 40) begin
      cyc++;
      or_v = !(cyc >= 4 && cyc <= 6);
      tick(1'b1, 8'hFF, idx, 1'b0, 1'b0, 1'b0, or_v, 1'b0);
      if (prev_v && !prev_or) begin
        chk("hold_vld", W'(obs_valid), W'(1));
        chk("hold_data", obs_data, prev_d);
      end
      if (obs_valid && !or_v) chk("stall_rdy", W'(obs_ready), W'(0));
      if (obs_ready) idx++;
      prev_v = obs_valid; prev_or = or_v; prev_d = obs_data;
    end
    chk("stream_accepted", W'(idx), W'(6));
    for (int i = 0; i < 8; i++) idle(1'b1);
    log_en = 1'b0;
    chk("stream_count", W'(got_q.size()), W'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("stream_%0d", i), (i < got_q.size()) ? got_q[i] : 'x, exp_s[i]);

    // reset with beats in flight
    tick(1'b1, 8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'hC3, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 8'h5A, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      chk("midrst_vld", W'(obs_valid), W'(0));
    end

    // randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 500; i++) begin
      tick(($urandom % 4) != 0, W'($urandom), int'($urandom % W), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom % 4) != 0, ($urandom % 128) == 0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
